// File: rtl/inst_fetch_unit.sv
// Fetch stage: PC, ready-handshake fetch from instruction memory, single-entry instruction register.
// One instruction per (memory latency + 2) cycles; In_Stall holds Out_Inst, In_Redirect flushes it.
module inst_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic        In_Clk,
  input  logic        In_Rst_n,
  output logic        Out_MemReq,
  output logic [15:0] Out_MemAddr,
  input  logic        In_MemReady,
  input  logic [15:0] In_MemData,
  input  logic        In_Stall,
  input  logic        In_Redirect,
  input  logic [15:0] In_RedirectPC,
  output logic [15:0] Out_Inst,
  output logic [15:0] Out_PC,
  output logic        Out_Valid
);

  typedef enum logic [1:0] {IDLE, FETCH, DISCARD, HOLD} state_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt;
  logic [15:0] redir_reg, redir_nxt;
  logic [15:0] inst_q, inst_nxt;
  logic [15:0] ipc_q, ipc_nxt;
  logic        valid_q, valid_nxt;
  logic        consume;

  assign consume = valid_q & ~In_Stall;

  always_ff @(posedge In_Clk or negedge In_Rst_n) begin
    if (!In_Rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      redir_reg <= 16'h0000;
      inst_q    <= 16'h0000;
      ipc_q     <= 16'h0000;
      valid_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      redir_reg <= redir_nxt;
      inst_q    <= inst_nxt;
      ipc_q     <= ipc_nxt;
      valid_q   <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    redir_nxt = redir_reg;
    inst_nxt  = inst_q;
    ipc_nxt   = ipc_q;
    valid_nxt = valid_q;
    case (state)
      IDLE: begin
        state_nxt = FETCH;
        if (In_Redirect) pc_nxt = In_RedirectPC;
      end
      FETCH: begin
        if (In_MemReady) begin
          if (In_Redirect) begin
            pc_nxt = In_RedirectPC;
          end else begin
            inst_nxt  = In_MemData;
            ipc_nxt   = pc;
            valid_nxt = 1'b1;
            pc_nxt    = pc + PC_STEP;
            state_nxt = HOLD;
          end
        end else if (In_Redirect) begin
          // Address must stay put until memory answers the outstanding request.
          redir_nxt = In_RedirectPC;
          state_nxt = DISCARD;
        end
      end
      DISCARD: begin
        if (In_MemReady) begin
          pc_nxt    = In_Redirect ? In_RedirectPC : redir_reg;
          state_nxt = FETCH;
        end else if (In_Redirect) begin
          redir_nxt = In_RedirectPC;
        end
      end
      HOLD: begin
        if (In_Redirect) begin
          pc_nxt    = In_RedirectPC;
          state_nxt = FETCH;
        end else if (consume) begin
          valid_nxt = 1'b0;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Flushed slot reads as opcode 0000 so the immediate generator sees zero.
    if (In_Redirect) begin
      valid_nxt = 1'b0;
      inst_nxt  = 16'h0000;
    end
  end

  assign Out_MemReq  = (state == FETCH) || (state == DISCARD);
  assign Out_MemAddr = pc;
  assign Out_Inst    = inst_q;
  assign Out_PC      = ipc_q;
  assign Out_Valid   = valid_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: transaction-level model checked every cycle plus directed literal checks.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_data = 16'h0000;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] inst, ipc;
  logic        valid;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int cnt = 0;

  inst_fetch_unit dut (
    .In_Clk(clk), .In_Rst_n(rst_n),
    .Out_MemReq(mem_req), .Out_MemAddr(mem_addr),
    .In_MemReady(mem_ready), .In_MemData(mem_data),
    .In_Stall(stall), .In_Redirect(redirect), .In_RedirectPC(redirect_pc),
    .Out_Inst(inst), .Out_PC(ipc), .Out_Valid(valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem(input logic [15:0] a);
    case (a)
      16'h0000: mem = 16'h1234;
      16'h0002: mem = 16'h5674;
      default:  mem = {a[7:0] ^ 8'h3C, a[15:8] ^ 8'h96};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory: answers after the request has been up for 'lat' cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 0;
    else if (mem_req && !mem_ready) cnt <= cnt + 1;
    else cnt <= 0;
  end

  always @(negedge clk) begin
    #1;
    mem_ready = mem_req && (cnt >= lat);
    mem_data  = mem_ready ? mem(mem_addr) : 16'hDEAD;
  end

  // Model: what the fetch stage must show, in terms of issued addresses and delivered words.
  logic [15:0] target, prev_addr, m_inst, m_pc;
  logic        m_valid, started, drop, prev_out;

  function automatic logic [15:0] exp_addr();
    return prev_out ? prev_addr : target;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic        req;
    logic [15:0] a;
    if (!rst_n) begin
      target = 16'h0000; prev_addr = 16'h0000; m_inst = 16'h0000; m_pc = 16'h0000;
      m_valid = 1'b0; started = 1'b0; drop = 1'b0; prev_out = 1'b0;
    end else begin
      req = started && !m_valid;
      a   = exp_addr();
      if (redirect) begin
        m_valid = 1'b0;
        m_inst  = 16'h0000;
        target  = redirect_pc;
      end else if (req && mem_ready && !drop) begin
        m_valid = 1'b1;
        m_inst  = mem(a);
        m_pc    = a;
        target  = a + 16'd2;
      end else if (m_valid && !stall) begin
        m_valid = 1'b0;
      end
      if (redirect && req && !mem_ready) drop = 1'b1;
      else if (req && mem_ready) drop = 1'b0;
      prev_out  = req && !mem_ready;
      prev_addr = a;
      started   = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("model_req", {15'd0, mem_req}, {15'd0, started && !m_valid});
    chk("model_addr", mem_addr, exp_addr());
    chk("model_valid", {15'd0, valid}, {15'd0, m_valid});
    chk("model_inst", inst, m_inst);
    chk("model_pc", ipc, m_pc);
  end

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!valid && n < 50) begin
      cyc();
      n++;
    end
    checks++;
    if (!valid) begin
      errors++;
      $display("FAIL %s: Out_Valid never rose within 50 cycles (got 0 expected 1)", nm);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_req"}, {15'd0, mem_req}, 16'd0);
    chk({nm, "_addr"}, mem_addr, 16'h0000);
    chk({nm, "_valid"}, {15'd0, valid}, 16'd0);
    chk({nm, "_inst"}, inst, 16'h0000);
    chk({nm, "_pc"}, ipc, 16'h0000);
  endtask

  initial begin
    repeat (3) cyc();
    chk_reset("reset");
    rst_n = 1'b1;
    #1 chk("first_cycle_req", {15'd0, mem_req}, 16'd0);
    cyc();
    chk("second_cycle_req", {15'd0, mem_req}, 16'd1);
    chk("second_cycle_addr", mem_addr, 16'h0000);

    wait_valid("word0");
    chk("word0_inst", inst, 16'h1234);
    chk("word0_pc", ipc, 16'h0000);
    cyc();
    chk("word0_single_pulse", {15'd0, valid}, 16'd0);
    chk("fetch2_addr", mem_addr, 16'h0002);
    wait_valid("word1");
    chk("word1_inst", inst, 16'h5674);
    chk("word1_pc", ipc, 16'h0002);

    // Stall five cycles on the word at 0x0004.
    cyc();
    wait_valid("word2");
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_inst", inst, mem(16'h0004));
      chk("stall_pc", ipc, 16'h0004);
      chk("stall_req", {15'd0, mem_req}, 16'd0);
    end
    stall = 1'b0;
    cyc();
    chk("post_stall_req", {15'd0, mem_req}, 16'd1);
    chk("post_stall_addr", mem_addr, 16'h0006);

    // Redirect during stalled hold.
    wait_valid("word3");
    stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
    cyc();
    redirect = 1'b0; stall = 1'b0;
    chk("hold_redir_valid", {15'd0, valid}, 16'd0);
    chk("hold_redir_inst", inst, 16'h0000);
    chk("hold_redir_req", {15'd0, mem_req}, 16'd1);
    chk("hold_redir_addr", mem_addr, 16'h0040);
    wait_valid("word40");
    chk("word40_inst", inst, mem(16'h0040));
    chk("word40_pc", ipc, 16'h0040);

    // Two redirects against a slow outstanding request to 0x0010.
    redirect = 1'b1; redirect_pc = 16'h0010; lat = 3;
    cyc();
    chk("slow_addr0", mem_addr, 16'h0010);
    redirect_pc = 16'h0080;
    cyc();
    chk("slow_addr1", mem_addr, 16'h0010);
    redirect_pc = 16'h00A0;
    cyc();
    redirect = 1'b0;
    chk("slow_addr2", mem_addr, 16'h0010);
    cyc();
    chk("slow_addr3", mem_addr, 16'h0010);
    chk("slow_no_valid", {15'd0, valid}, 16'd0);
    cyc();
    chk("discard_target_addr", mem_addr, 16'h00A0);
    chk("discard_target_req", {15'd0, mem_req}, 16'd1);
    chk("discard_no_valid", {15'd0, valid}, 16'd0);

    // Redirect coincident with the memory response.
    lat = 1;
    for (int n = 0; n < 10 && !mem_ready; n++) cyc();
    redirect = 1'b1; redirect_pc = 16'h0100;
    cyc();
    redirect = 1'b0;
    chk("coinc_valid", {15'd0, valid}, 16'd0);
    chk("coinc_addr", mem_addr, 16'h0100);
    chk("coinc_req", {15'd0, mem_req}, 16'd1);
    wait_valid("word100");
    chk("word100_inst", inst, mem(16'h0100));
    chk("word100_pc", ipc, 16'h0100);

    // PC wrap at 0xFFFE.
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    cyc();
    redirect = 1'b0;
    wait_valid("wordFFFE");
    chk("wrap_pc", ipc, 16'hFFFE);
    chk("wrap_inst", inst, mem(16'hFFFE));
    cyc();
    chk("wrap_addr", mem_addr, 16'h0000);
    chk("wrap_req", {15'd0, mem_req}, 16'd1);

    // Asynchronous reset in the middle of a request.
    rst_n = 1'b0;
    #1 chk_reset("async_reset");
    repeat (2) cyc();
    rst_n = 1'b1;
    wait_valid("after_reset");
    chk("after_reset_inst", inst, 16'h1234);
    chk("after_reset_pc", ipc, 16'h0000);

    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete (got timeout expected finish)");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the immediate generator and decoder.
- Keeps the program counter and runs a ready-based request handshake to instruction memory.
- Latches each returned 16-bit instruction into an instruction register (Out_Inst); this register feeds the immediate generator's instruction input.
- Handles downstream stall and redirect (branch/jump target) with flush of the held instruction.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
PC_STEP, 2, PC increment per fetched instruction (byte-addressed, 16-bit instructions)

Ports:
In_Clk  input  1  clock, all state on rising edge
In_Rst_n  input  1  asynchronous active-low reset
Out_MemReq  output  1  instruction memory request
Out_MemAddr  output  16  fetch address, stable while Out_MemReq high
In_MemReady  input  1  memory response; In_MemData valid this cycle, request completes
In_MemData  input  16  instruction word from memory
In_Stall  input  1  downstream cannot accept Out_Inst this cycle
In_Redirect  input  1  one-cycle pulse: discard fetched/held instruction, continue at In_RedirectPC
In_RedirectPC  input  16  redirect target
Out_Inst  output  16  instruction register (to immediate generator/decoder)
Out_PC  output  16  address of Out_Inst
Out_Valid  output  1  Out_Inst holds a live instruction

Behaviour:
- Reset (async, In_Rst_n=0):
  - PC=RESET_PC, RedirReg=0, state=IDLE.
  - Out_Inst=16'h0000, Out_PC=16'h0000, Out_Valid=0, Out_MemReq=0, Out_MemAddr=RESET_PC.
  - Reset asserted mid-request abandons it; any response after reset release before a new request is ignored.
- Decode: consume = Out_Valid & ~In_Stall.
- Outputs: Out_MemReq=1 in FETCH and DISCARD, else 0. Out_MemAddr=PC in every state.
- States:
  - IDLE: next FETCH unconditionally. Out_MemReq is first asserted in the 2nd cycle after reset release.
  - FETCH: request PC, wait for In_MemReady (any number of cycles; no timeout).
    - Ready, no redirect: Out_Inst<=In_MemData, Out_PC<=PC, Out_Valid<=1, PC<=PC+PC_STEP, go HOLD.
    - Ready with redirect same cycle: discard data, PC<=In_RedirectPC, stay FETCH. The new address is requested the next cycle.
    - Redirect without ready: RedirReg<=In_RedirectPC, go DISCARD. PC and Out_MemAddr must not change while the request is outstanding.
  - DISCARD: keep requesting the old PC.
    - Further redirect overwrites RedirReg. Latest target wins; a redirect coincident with ready also wins.
    - On ready: drop data, PC<=RedirReg (or In_RedirectPC if coincident), go FETCH. Out_Valid stays 0.
  - HOLD: Out_Inst held stable, no request.
    - consume: Out_Valid<=0, go FETCH.
    - Stalled: hold indefinitely.
- Redirect in HOLD:
  - Out_Valid<=0, Out_Inst<=16'h0000 (opcode 0000 decodes to zero immediate), PC<=In_RedirectPC, go FETCH.
  - Redirect has priority over stall and consume.
- Any redirect also clears Out_Valid and Out_Inst on the next edge, in all states.
- Throughput: one instruction per (memory latency + 2) cycles minimum. No prefetch, single-entry instruction register.
- PC arithmetic is 16-bit modulo: 16'hFFFE+2 wraps to 16'h0000 with no flag.
- In_MemReady outside FETCH/DISCARD is ignored.

Test Plan:
- Reset, RESET_PC=0, memory ready 1 cycle after each request returning 16'h1234 then 16'h5674, no stall -> Out_MemReq rises 2nd cycle after release at addr 0. Out_Inst=1234/Out_PC=0 valid, then 5674/Out_PC=2. Out_Valid never high 2 cycles for the same word unless stalled.
- Hold In_Stall=1 for 5 cycles while Out_Valid=1 -> Out_Inst/Out_PC unchanged, Out_MemReq=0. Next fetch at PC+2 starts the cycle after stall drops.
- Redirect to 16'h0040 during HOLD with stall=1 -> next cycle Out_Valid=0, Out_Inst=0000, request at 0040.
- Redirect to 16'h0080 while request to 0x0010 outstanding (ready 3 cycles later), plus a second redirect to 16'h00A0 1 cycle later -> addr stays 0010 until ready, data dropped, next request at 00A0, no valid pulse.
- Redirect coincident with In_MemReady -> data dropped, next request at target.
- PC at 16'hFFFE -> next request at 16'h0000. Assert In_Rst_n=0 mid-request -> all outputs return to reset values immediately (asynchronously).
